// File: rtl/seg_unit_ovr.sv
// rtl/seg_unit_ovr.sv - 8086 segment registers with override latch, SS interrupt shadow and registered address generation
//
// Ports:
//   clk, rst        : clock; synchronous active-high reset
//   seg_wr_*        : segment register write (sel 00=ES 01=CS 10=SS 11=DS)
//   ovr_valid/sel   : segment-override prefix decoded this cycle
//   instr_done      : current instruction retires (one-cycle pulse)
//   ea_*            : address request (default segment, override bypass, offset)
//   cs/ds/ss/es     : register contents
//   ovr_active      : an override prefix is latched
//   int_inhibit     : interrupts must not be accepted (SS-write shadow)
//   ea_valid/addr/seg_used : registered result, one cycle after ea_req

module seg_unit_ovr #(
  parameter int               SEG_W    = 16,
  parameter int               OFF_W    = 16,
  parameter int               ADDR_W   = 20,
  parameter int               SHIFT    = 4,
  parameter logic [SEG_W-1:0] CS_RESET = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seg_wr_en,
  input  logic [1:0]        seg_wr_sel,
  input  logic [SEG_W-1:0]  seg_wr_data,
  input  logic              ovr_valid,
  input  logic [1:0]        ovr_sel,
  input  logic              instr_done,
  input  logic              ea_req,
  input  logic [1:0]        ea_default_sel,
  input  logic              ea_no_ovr,
  input  logic [OFF_W-1:0]  ea_offset,
  output logic [SEG_W-1:0]  cs,
  output logic [SEG_W-1:0]  ds,
  output logic [SEG_W-1:0]  ss,
  output logic [SEG_W-1:0]  es,
  output logic              ovr_active,
  output logic              int_inhibit,
  output logic              ea_valid,
  output logic [ADDR_W-1:0] ea_addr,
  output logic [1:0]        ea_seg_used
);

  localparam logic [1:0] SEL_ES = 2'b00;
  localparam logic [1:0] SEL_CS = 2'b01;
  localparam logic [1:0] SEL_SS = 2'b10;

  typedef enum logic [1:0] {
    INH_IDLE  = 2'd0,
    INH_ARMED = 2'd1,
    INH_HOLD  = 2'd2
  } inh_state_e;

  logic [SEG_W-1:0]  cs_q, cs_d, ds_q, ds_d, ss_q, ss_d, es_q, es_d;
  logic              ovr_active_q, ovr_active_d;
  logic [1:0]        ovr_sel_q, ovr_sel_d;
  inh_state_e        inh_q, inh_d;
  logic              ea_valid_q, ea_valid_d;
  logic [ADDR_W-1:0] ea_addr_q, ea_addr_d;
  logic [1:0]        ea_seg_q, ea_seg_d;

  logic [1:0]        seg_sel;
  logic [SEG_W-1:0]  seg_reg;
  logic [SEG_W-1:0]  seg_eff;
  logic              ss_wr;

  assign ss_wr = seg_wr_en && (seg_wr_sel == SEL_SS);

  // Register file writes
  always_comb begin
    cs_d = cs_q;
    ds_d = ds_q;
    ss_d = ss_q;
    es_d = es_q;
    if (seg_wr_en) begin
      case (seg_wr_sel)
        SEL_ES:  es_d = seg_wr_data;
        SEL_CS:  cs_d = seg_wr_data;
        SEL_SS:  ss_d = seg_wr_data;
        default: ds_d = seg_wr_data;
      endcase
    end
  end

  // Override latch: a new prefix wins over instr_done because it belongs
  // to the instruction that starts after the retiring one.
  always_comb begin
    ovr_active_d = ovr_active_q;
    ovr_sel_d    = ovr_sel_q;
    if (ovr_valid) begin
      ovr_active_d = 1'b1;
      ovr_sel_d    = ovr_sel;
    end else if (instr_done) begin
      ovr_active_d = 1'b0;
    end
  end

  // Address generation. The override used is the one already latched, so a
  // prefix arriving with the request does not affect it.
  always_comb begin
    seg_sel = (ovr_active_q && !ea_no_ovr) ? ovr_sel_q : ea_default_sel;
    case (seg_sel)
      SEL_ES:  seg_reg = es_q;
      SEL_CS:  seg_reg = cs_q;
      SEL_SS:  seg_reg = ss_q;
      default: seg_reg = ds_q;
    endcase
    // Same-cycle write to the chosen segment is forwarded
    seg_eff = (seg_wr_en && (seg_wr_sel == seg_sel)) ? seg_wr_data : seg_reg;

    ea_valid_d = ea_req;
    ea_addr_d  = ea_addr_q;
    ea_seg_d   = ea_seg_q;
    if (ea_req) begin
      // ADDR_W-wide arithmetic wraps the sum naturally
      ea_addr_d = (ADDR_W'(seg_eff) << SHIFT) + ADDR_W'(ea_offset);
      ea_seg_d  = seg_sel;
    end
  end

  // Interrupt shadow FSM: ARMED waits for the SS-writing instruction to
  // retire, HOLD covers the instruction after it.
  always_comb begin
    inh_d = inh_q;
    if (ss_wr) begin
      inh_d = instr_done ? INH_HOLD : INH_ARMED;
    end else begin
      case (inh_q)
        INH_ARMED: if (instr_done) inh_d = INH_HOLD;
        INH_HOLD:  if (instr_done) inh_d = INH_IDLE;
        default:   inh_d = INH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q         <= CS_RESET;
      ds_q         <= '0;
      ss_q         <= '0;
      es_q         <= '0;
      ovr_active_q <= 1'b0;
      ovr_sel_q    <= 2'b00;
      inh_q        <= INH_IDLE;
      ea_valid_q   <= 1'b0;
      ea_addr_q    <= '0;
      ea_seg_q     <= 2'b00;
    end else begin
      cs_q         <= cs_d;
      ds_q         <= ds_d;
      ss_q         <= ss_d;
      es_q         <= es_d;
      ovr_active_q <= ovr_active_d;
      ovr_sel_q    <= ovr_sel_d;
      inh_q        <= inh_d;
      ea_valid_q   <= ea_valid_d;
      ea_addr_q    <= ea_addr_d;
      ea_seg_q     <= ea_seg_d;
    end
  end

  assign cs          = cs_q;
  assign ds          = ds_q;
  assign ss          = ss_q;
  assign es          = es_q;
  assign ovr_active  = ovr_active_q;
  assign int_inhibit = (inh_q != INH_IDLE);
  assign ea_valid    = ea_valid_q;
  assign ea_addr     = ea_addr_q;
  assign ea_seg_used = ea_seg_q;

endmodule

// File: tb/tb_seg_unit_ovr.sv
// tb/tb_seg_unit_ovr.sv - scoreboard bench for seg_unit_ovr with a behavioural reference model

module tb_seg_unit_ovr;

  logic        clk = 1'b0;
  logic        rst;
  logic        seg_wr_en;
  logic [1:0]  seg_wr_sel;
  logic [15:0] seg_wr_data;
  logic        ovr_valid;
  logic [1:0]  ovr_sel;
  logic        instr_done;
  logic        ea_req;
  logic [1:0]  ea_default_sel;
  logic        ea_no_ovr;
  logic [15:0] ea_offset;
  logic [15:0] cs, ds, ss, es;
  logic        ovr_active, int_inhibit, ea_valid;
  logic [19:0] ea_addr;
  logic [1:0]  ea_seg_used;

  seg_unit_ovr dut (
    .clk(clk), .rst(rst),
    .seg_wr_en(seg_wr_en), .seg_wr_sel(seg_wr_sel), .seg_wr_data(seg_wr_data),
    .ovr_valid(ovr_valid), .ovr_sel(ovr_sel), .instr_done(instr_done),
    .ea_req(ea_req), .ea_default_sel(ea_default_sel), .ea_no_ovr(ea_no_ovr),
    .ea_offset(ea_offset),
    .cs(cs), .ds(ds), .ss(ss), .es(es),
    .ovr_active(ovr_active), .int_inhibit(int_inhibit),
    .ea_valid(ea_valid), .ea_addr(ea_addr), .ea_seg_used(ea_seg_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [19:0] addr;
    logic [1:0]  sel;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  logic mon_en = 1'b0;

  // Reference model state: registers indexed by sreg encoding (0=ES 1=CS 2=SS 3=DS)
  int          mseg[4];
  logic        m_ovr;
  logic [1:0]  m_osel;
  int          m_inh_left;   // instr_done pulses still needed before interrupts reopen
  logic [19:0] m_last_addr;
  logic [1:0]  m_last_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_update();
    int   sel;
    int   segv;
    exp_t e;
    if (rst) begin
      mseg[0] = 0; mseg[1] = 'hFFFF; mseg[2] = 0; mseg[3] = 0;
      m_ovr = 1'b0; m_osel = 2'b00; m_inh_left = 0;
      m_last_addr = 20'h0; m_last_sel = 2'b00;
    end else begin
      if (ea_req) begin
        sel  = (m_ovr && !ea_no_ovr) ? int'(m_osel) : int'(ea_default_sel);
        segv = (seg_wr_en && int'(seg_wr_sel) == sel) ? int'(seg_wr_data) : mseg[sel];
        e.due  = edge_n + 1;
        e.addr = 20'((segv * 16 + int'(ea_offset)) % 1048576);
        e.sel  = 2'(sel);
        q.push_back(e);
        m_last_addr = e.addr;
        m_last_sel  = e.sel;
      end
      if (seg_wr_en) mseg[seg_wr_sel] = int'(seg_wr_data);
      if (ovr_valid) begin
        m_ovr  = 1'b1;
        m_osel = ovr_sel;
      end else if (instr_done) begin
        m_ovr = 1'b0;
      end
      if (seg_wr_en && seg_wr_sel == 2'd2) m_inh_left = instr_done ? 1 : 2;
      else if (instr_done && m_inh_left > 0) m_inh_left--;
    end
  endtask

  task automatic clear_in();
    rst = 1'b0; seg_wr_en = 1'b0; seg_wr_sel = 2'b00; seg_wr_data = 16'h0;
    ovr_valid = 1'b0; ovr_sel = 2'b00; instr_done = 1'b0;
    ea_req = 1'b0; ea_default_sel = 2'b00; ea_no_ovr = 1'b0; ea_offset = 16'h0;
  endtask

  // One clock: inputs already set; model follows the edge; returns at edge+1
  task automatic tick();
    @(posedge clk);
    model_update();
    edge_n++;
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [15:0] d);
    seg_wr_en = 1'b1; seg_wr_sel = s; seg_wr_data = d;
  endtask

  task automatic req(input logic [1:0] dsel, input logic [15:0] off, input logic noovr);
    ea_req = 1'b1; ea_default_sel = dsel; ea_offset = off; ea_no_ovr = noovr;
  endtask

  // Monitor: mid-cycle, compares outputs with the model and pops the scoreboard
  initial begin
    exp_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (q.size() > 0 && q[0].due < edge_n) begin
          e = q.pop_front();
          chk("ea_result_missed", 32'(edge_n), 32'(e.due));
        end
        exp_v = (q.size() > 0) && (q[0].due == edge_n);
        chk("ea_valid", 32'(ea_valid), 32'(exp_v));
        if (exp_v) begin
          e = q.pop_front();
          chk("sb_ea_addr", 32'(ea_addr), 32'(e.addr));
          chk("sb_ea_seg_used", 32'(ea_seg_used), 32'(e.sel));
        end
        chk("hold_ea_addr", 32'(ea_addr), 32'(m_last_addr));
        chk("hold_ea_seg_used", 32'(ea_seg_used), 32'(m_last_sel));
        chk("es", 32'(es), 32'(mseg[0]));
        chk("cs", 32'(cs), 32'(mseg[1]));
        chk("ss", 32'(ss), 32'(mseg[2]));
        chk("ds", 32'(ds), 32'(mseg[3]));
        chk("ovr_active", 32'(ovr_active), 32'(m_ovr));
        chk("int_inhibit", 32'(int_inhibit), 32'(m_inh_left > 0));
      end
    end
  end

  initial begin
    clear_in();
    rst = 1'b1;
    tick(); tick();
    clear_in();
    mon_en = 1'b1;

    // Reset values
    chk("rst_cs", 32'(cs), 32'h0000_FFFF);
    chk("rst_ds", 32'(ds), 32'h0);
    chk("rst_ss", 32'(ss), 32'h0);
    chk("rst_es", 32'(es), 32'h0);
    chk("rst_ea_valid", 32'(ea_valid), 32'h0);
    chk("rst_int_inhibit", 32'(int_inhibit), 32'h0);
    tick();

    // CS reset vector
    req(2'b01, 16'h0000, 1'b0); tick(); clear_in();
    chk("plan_cs_addr", 32'(ea_addr), 32'h000F_FFF0);
    chk("plan_cs_valid", 32'(ea_valid), 32'h1);

    // Wrap-around and top of segment
    wr(2'b11, 16'hFFFF); tick(); clear_in();
    req(2'b11, 16'h0010, 1'b0); tick(); clear_in();
    chk("plan_wrap_addr", 32'(ea_addr), 32'h0);
    chk("plan_wrap_seg", 32'(ea_seg_used), 32'h3);
    wr(2'b11, 16'h1000); tick(); clear_in();
    req(2'b11, 16'hFFFF, 1'b0); tick(); clear_in();
    chk("plan_top_addr", 32'(ea_addr), 32'h0001_FFFF);

    // Override flow
    wr(2'b00, 16'h2000); tick(); clear_in();
    ovr_valid = 1'b1; ovr_sel = 2'b00; tick(); clear_in();
    chk("plan_ovr_set", 32'(ovr_active), 32'h1);
    req(2'b11, 16'h0004, 1'b0); tick(); clear_in();
    chk("plan_ovr_addr", 32'(ea_addr), 32'h0002_0004);
    chk("plan_ovr_seg", 32'(ea_seg_used), 32'h0);
    req(2'b11, 16'h0004, 1'b1); tick(); clear_in();
    chk("plan_noovr_addr", 32'(ea_addr), 32'h0001_0004);
    instr_done = 1'b1; tick(); clear_in();
    chk("plan_ovr_clear", 32'(ovr_active), 32'h0);

    // Same-cycle write bypass
    wr(2'b10, 16'h3000); req(2'b10, 16'h0002, 1'b0); tick(); clear_in();
    chk("plan_bypass_addr", 32'(ea_addr), 32'h0003_0002);
    instr_done = 1'b1; tick(); tick(); clear_in(); tick();
    chk("inh_idle", 32'(int_inhibit), 32'h0);

    // Inhibit: write, done, done
    wr(2'b10, 16'h1234); tick(); clear_in();
    chk("inh_armed", 32'(int_inhibit), 32'h1);
    tick();
    instr_done = 1'b1; tick(); clear_in();
    chk("inh_hold", 32'(int_inhibit), 32'h1);
    tick();
    instr_done = 1'b1; tick(); clear_in();
    chk("inh_release", 32'(int_inhibit), 32'h0);

    // Inhibit: write with coincident done
    wr(2'b10, 16'h4321); instr_done = 1'b1; tick(); clear_in();
    chk("inh_direct_hold", 32'(int_inhibit), 32'h1);
    tick();
    instr_done = 1'b1; tick(); clear_in();
    chk("inh_direct_release", 32'(int_inhibit), 32'h0);

    // Inhibit: re-arm from HOLD
    wr(2'b10, 16'h0001); instr_done = 1'b1; tick(); clear_in();
    wr(2'b10, 16'h0002); tick(); clear_in();
    instr_done = 1'b1; tick(); clear_in();
    chk("inh_rearm_still", 32'(int_inhibit), 32'h1);
    instr_done = 1'b1; tick(); clear_in();
    chk("inh_rearm_release", 32'(int_inhibit), 32'h0);

    // Prefix coincident with instr_done stays latched
    ovr_valid = 1'b1; ovr_sel = 2'b10; instr_done = 1'b1; tick(); clear_in();
    chk("ovr_set_wins", 32'(ovr_active), 32'h1);
    instr_done = 1'b1; tick(); clear_in();

    // Reset with a request pending
    wr(2'b10, 16'h5555); tick(); clear_in();
    ovr_valid = 1'b1; ovr_sel = 2'b01; tick(); clear_in();
    req(2'b01, 16'h0123, 1'b0); rst = 1'b1; tick(); clear_in();
    chk("rst_pend_valid", 32'(ea_valid), 32'h0);
    chk("rst_pend_ovr", 32'(ovr_active), 32'h0);
    chk("rst_pend_inh", 32'(int_inhibit), 32'h0);
    chk("rst_pend_cs", 32'(cs), 32'h0000_FFFF);
    chk("rst_pend_addr", 32'(ea_addr), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clear_in();
      rst        = ($urandom_range(0, 99) == 0);
      seg_wr_en  = ($urandom_range(0, 3) == 0);
      seg_wr_sel = 2'($urandom_range(0, 3));
      seg_wr_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ovr_valid  = ($urandom_range(0, 6) == 0);
      ovr_sel    = 2'($urandom_range(0, 3));
      instr_done = ($urandom_range(0, 3) == 0);
      ea_req     = ($urandom_range(0, 1) == 1);
      ea_default_sel = 2'($urandom_range(0, 3));
      ea_no_ovr  = ($urandom_range(0, 3) == 0);
      ea_offset  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      tick();
    end
    clear_in();
    tick(); tick();
    mon_en = 1'b0;
    chk("sb_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
